// File: rtl/dcache_controller_if.sv
// Signal bundle between the MEM stage, the data cache controller and main memory.
// The slave modport is the cache side and the master modport is the CPU/memory side.
interface dcache_controller_if;
  logic         cpu_req_i;
  logic         cpu_write_i;
  logic [31:0]  cpu_addr_i;
  logic [31:0]  cpu_data_i;
  logic [31:0]  cpu_data_o;
  logic         cpu_stall_o;
  logic         mem_enable_o;
  logic         mem_write_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic [255:0] mem_data_i;
  logic         mem_ack_i;

  modport slave (
    input  cpu_req_i, cpu_write_i, cpu_addr_i, cpu_data_i, mem_data_i, mem_ack_i,
    output cpu_data_o, cpu_stall_o, mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
  );

  modport master (
    output cpu_req_i, cpu_write_i, cpu_addr_i, cpu_data_i, mem_data_i, mem_ack_i,
    input  cpu_data_o, cpu_stall_o, mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
  );
endinterface

// File: rtl/dcache_controller.sv
// Direct-mapped write-back data cache controller: 16 sets of 32-byte lines.
// Hits complete combinationally; misses write back a dirty victim and then refill the line.
module dcache_controller (
  input  logic             clk_i,
  input  logic             rst_i,
  dcache_controller_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WB_REQ, AL_REQ} state_t;

  state_t        r_state;
  state_t        w_nextState;
  logic [15:0]   r_valid;
  logic [15:0]   r_dirty;
  logic [22:0]   r_tag  [16];
  logic [255:0]  r_data [16];
  logic [22:0]   r_missTag;
  logic [3:0]    r_missIdx;

  logic [22:0]   w_tag;
  logic [3:0]    w_idx;
  logic [2:0]    w_word;
  logic          w_hit;
  logic          w_idleHit;
  logic          w_missStart;
  logic          w_storeHit;
  logic          w_wbDone;
  logic          w_fillDone;
  logic [31:0]   w_rdWord;
  logic [1:0]    w_unused;

  assign w_tag    = bus.cpu_addr_i[31:9];
  assign w_idx    = bus.cpu_addr_i[8:5];
  assign w_word   = bus.cpu_addr_i[4:2];
  assign w_unused = bus.cpu_addr_i[1:0];

  assign w_hit       = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_rdWord    = r_data[w_idx][{w_word, 5'b0} +: 32];
  assign w_idleHit   = (r_state == IDLE) && w_hit;
  assign w_missStart = (r_state == IDLE) && bus.cpu_req_i && !w_hit;
  assign w_storeHit  = bus.cpu_req_i && bus.cpu_write_i && w_idleHit;
  assign w_wbDone    = (r_state == WB_REQ) && bus.mem_ack_i;
  assign w_fillDone  = (r_state == AL_REQ) && bus.mem_ack_i;

  assign bus.cpu_stall_o = bus.cpu_req_i && !w_idleHit;
  assign bus.cpu_data_o  = (bus.cpu_req_i && !bus.cpu_write_i && w_idleHit) ? w_rdWord : 32'h0;

  // Memory-side requests use the latched miss index/tag so CPU input changes under stall are harmless.
  always_comb begin
    w_nextState      = r_state;
    bus.mem_enable_o = 1'b0;
    bus.mem_write_o  = 1'b0;
    bus.mem_addr_o   = 32'h0;
    bus.mem_data_o   = 256'h0;
    unique case (r_state)
      IDLE: begin
        if (w_missStart) begin
          w_nextState = (r_valid[w_idx] && r_dirty[w_idx]) ? WB_REQ : AL_REQ;
        end
      end
      WB_REQ: begin
        bus.mem_enable_o = 1'b1;
        bus.mem_write_o  = 1'b1;
        bus.mem_addr_o   = {r_tag[r_missIdx], r_missIdx, 5'b0};
        bus.mem_data_o   = r_data[r_missIdx];
        if (bus.mem_ack_i) w_nextState = AL_REQ;
      end
      AL_REQ: begin
        bus.mem_enable_o = 1'b1;
        bus.mem_addr_o   = {r_missTag, r_missIdx, 5'b0};
        if (bus.mem_ack_i) w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_valid <= 16'h0;
      r_dirty <= 16'h0;
    end else begin
      r_state <= w_nextState;
      if (w_storeHit) r_dirty[w_idx] <= 1'b1;
      if (w_wbDone) r_dirty[r_missIdx] <= 1'b0;
      if (w_fillDone) begin
        r_valid[r_missIdx] <= 1'b1;
        r_dirty[r_missIdx] <= 1'b0;
      end
    end
  end

  // Tag/data arrays are not cleared by reset, but a reset cycle must never write them.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (w_missStart) begin
        r_missTag <= w_tag;
        r_missIdx <= w_idx;
      end
      if (w_storeHit) r_data[w_idx][{w_word, 5'b0} +: 32] <= bus.cpu_data_i;
      if (w_fillDone) begin
        r_data[r_missIdx] <= bus.mem_data_i;
        r_tag[r_missIdx]  <= r_missTag;
      end
    end
  end
endmodule

// File: tb/tb_dcache_controller.sv
// Randomized scoreboard bench for dcache_controller: the cache is modelled as transparent
// memory plus a set-occupancy table that predicts hits, write-backs and miss latency.
module tb_dcache_controller;
  logic clk;
  logic rst;

  dcache_controller_if bus ();

  dcache_controller dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0]  data;
    bit           expWb;
    logic [31:0]  wbAddr;
    logic [255:0] wbLine;
    bit           expFill;
    logic [31:0]  fillAddr;
  } exp_t;

  exp_t expQ[$];
  int checks = 0;
  int errors = 0;

  // Reference: what the CPU should see (gold) and what main memory holds.
  bit           mValid [16];
  bit           mDirty [16];
  logic [22:0]  mTag   [16];
  logic [31:0]  gold    [logic [29:0]];
  logic [255:0] mainMem [logic [26:0]];

  bit           memBusy = 0;
  bit           memAckReal = 0;
  bit           memWrite;
  int           memK, memN;
  int           forceLat = 0;
  logic [31:0]  memAddr;
  logic [255:0] memData;

  int           wbCnt = 0, fillCnt = 0, wbN = 0, fillN = 0;
  logic [31:0]  wbAddrLog, fillAddrLog;
  logic [255:0] wbDataLog;
  int           stallCnt = 0;
  int           lastStall = 0;

  function automatic logic [31:0] initWord(logic [29:0] wa);
    return ({2'b0, wa} * 32'h9E3779B1) ^ 32'h5A5AC3C3;
  endfunction

  function automatic logic [255:0] readLine(logic [26:0] la);
    logic [255:0] l;
    if (mainMem.exists(la)) return mainMem[la];
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = initWord({la, w[2:0]});
    return l;
  endfunction

  function automatic logic [31:0] goldRead(logic [29:0] wa);
    logic [255:0] l;
    if (gold.exists(wa)) return gold[wa];
    l = readLine(wa[29:3]);
    return l[wa[2:0]*32 +: 32];
  endfunction

  task automatic checkOutput(string name, logic [255:0] actual, logic [255:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 16; i++) begin
      mValid[i] = 0;
      mDirty[i] = 0;
    end
    gold.delete();
  endtask

  // Memory responder: random or forced latency, occasional stray acks while idle.
  task automatic memStep();
    if (bus.mem_ack_i) begin
      bus.mem_ack_i = 1'b0;
      if (memAckReal) memBusy = 0;
      memAckReal = 0;
    end
    if (bus.mem_enable_o) begin
      if (!memBusy) begin
        memBusy  = 1;
        memK     = 0;
        memN     = (forceLat > 0) ? forceLat : int'($urandom_range(1, 4));
        memWrite = bus.mem_write_o;
        memAddr  = bus.mem_addr_o;
        memData  = bus.mem_data_o;
        checkOutput("mem_addr_aligned", 256'(memAddr[4:0]), 256'(0));
      end else begin
        checkOutput("mem_req_stable", 256'({bus.mem_write_o, bus.mem_addr_o}), 256'({memWrite, memAddr}));
        checkOutput("mem_data_stable", bus.mem_data_o, memData);
      end
      memK++;
      if (memK == memN) begin
        bus.mem_ack_i = 1'b1;
        memAckReal = 1;
        if (memWrite) begin
          mainMem[memAddr[31:5]] = memData;
          bus.mem_data_i = {8{$urandom}};
          wbCnt++;
          wbN = memK;
          wbAddrLog = memAddr;
          wbDataLog = memData;
        end else begin
          bus.mem_data_i = readLine(memAddr[31:5]);
          fillCnt++;
          fillN = memK;
          fillAddrLog = memAddr;
        end
      end
    end else if (!memBusy && $urandom_range(0, 7) == 0) begin
      bus.mem_ack_i  = 1'b1;
      bus.mem_data_i = {8{$urandom}};
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    memStep();
  endtask

  task automatic idle(int n);
    bus.cpu_req_i = 1'b0;
    repeat (n) tick();
  endtask

  task automatic applyStimulus(bit write, logic [31:0] addr, logic [31:0] data);
    exp_t e;
    logic [3:0]  idx = addr[8:5];
    logic [22:0] tag = addr[31:9];
    logic [29:0] wa  = addr[31:2];
    bit hit;
    int cycles = 0;
    hit        = mValid[idx] && (mTag[idx] == tag);
    e.data     = write ? 32'h0 : goldRead(wa);
    e.expFill  = !hit;
    e.fillAddr = {tag, idx, 5'b0};
    e.expWb    = !hit && mValid[idx] && mDirty[idx];
    e.wbAddr   = {mTag[idx], idx, 5'b0};
    for (int w = 0; w < 8; w++) e.wbLine[w*32 +: 32] = goldRead({mTag[idx], idx, w[2:0]});
    expQ.push_back(e);
    if (!hit) begin
      mValid[idx] = 1;
      mTag[idx]   = tag;
      mDirty[idx] = 0;
    end
    if (write) begin
      mDirty[idx] = 1;
      gold[wa]    = data;
    end
    bus.cpu_req_i   = 1'b1;
    bus.cpu_write_i = write;
    bus.cpu_addr_i  = addr;
    bus.cpu_data_i  = data;
    forever begin
      @(negedge clk);
      if (!bus.cpu_stall_o) break;
      cycles++;
      if (cycles > 500) begin
        errors++;
        checks++;
        $display("[TB] FAIL access_timeout: still stalled after %0d cycles, required completion", cycles);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "[TB] access timeout");
      end
      tick();
      if (bus.mem_enable_o) begin
        bus.cpu_addr_i = $urandom;
        bus.cpu_data_i = $urandom;
      end else begin
        bus.cpu_addr_i = addr;
        bus.cpu_data_i = data;
      end
    end
    tick();
  endtask

  task automatic checkCompletion();
    exp_t e;
    int expStall;
    if (expQ.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL unexpected_completion: got completion, required none pending");
      return;
    end
    e = expQ.pop_front();
    checkOutput("cpu_data", 256'(bus.cpu_data_o), 256'(e.data));
    expStall = e.expFill ? 1 + (e.expWb ? wbN : 0) + fillN : 0;
    checkOutput("stall_cycles", 256'(stallCnt), 256'(expStall));
    checkOutput("wb_count", 256'(wbCnt), 256'(e.expWb ? 1 : 0));
    checkOutput("fill_count", 256'(fillCnt), 256'(e.expFill ? 1 : 0));
    if (e.expWb && wbCnt == 1) begin
      checkOutput("wb_addr", 256'(wbAddrLog), 256'(e.wbAddr));
      checkOutput("wb_line", wbDataLog, e.wbLine);
    end
    if (e.expFill && fillCnt == 1) checkOutput("fill_addr", 256'(fillAddrLog), 256'(e.fillAddr));
    lastStall = stallCnt;
    stallCnt = 0;
    wbCnt = 0;
    fillCnt = 0;
  endtask

  // Monitor: counts stall cycles and checks each completed access against the queue.
  always @(negedge clk) begin
    if (rst) begin
      stallCnt = 0;
      wbCnt = 0;
      fillCnt = 0;
    end else if (bus.cpu_req_i) begin
      if (bus.cpu_stall_o) stallCnt++;
      else checkCompletion();
    end else begin
      checkOutput("idle_stall", 256'(bus.cpu_stall_o), 256'(0));
      checkOutput("idle_mem_req", 256'({bus.mem_enable_o, bus.mem_write_o}), 256'(0));
      checkOutput("idle_cpu_data", 256'(bus.cpu_data_o), 256'(0));
    end
  end

  initial begin
    logic [255:0] l;
    logic [22:0]  t;
    logic [3:0]   ix;
    logic [2:0]   wd;
    logic [1:0]   lo;
    int n;
    rst = 1'b1;
    bus.cpu_req_i   = 1'b0;
    bus.cpu_write_i = 1'b0;
    bus.cpu_addr_i  = 32'h0;
    bus.cpu_data_i  = 32'h0;
    bus.mem_data_i  = 256'h0;
    bus.mem_ack_i   = 1'b0;
    l = readLine(27'h2);
    l[63:32] = 32'hDEADBEEF;
    mainMem[27'h2] = l;
    modelReset();
    repeat (3) tick();
    rst = 1'b0;
    idle(2);

    // Cold load with a 3-cycle fill, then store hit, load hit and dirty eviction.
    forceLat = 3;
    applyStimulus(0, 32'h0000_0044, 32'h0);
    forceLat = 0;
    checkOutput("cold_load_stall", 256'(lastStall), 256'(4));
    applyStimulus(1, 32'h0000_0048, 32'h1234_5678);
    checkOutput("store_hit_stall", 256'(lastStall), 256'(0));
    applyStimulus(0, 32'h0000_0048, 32'h0);
    checkOutput("load_hit_stall", 256'(lastStall), 256'(0));
    applyStimulus(0, 32'h0000_0240, 32'h0);

    // Long fill while the CPU address wanders, then an idle stretch.
    forceLat = 21;
    applyStimulus(0, 32'h0000_1000, 32'h0);
    forceLat = 0;
    checkOutput("slow_fill_stall", 256'(lastStall), 256'(22));
    idle(10);
    applyStimulus(0, 32'h0000_0244, 32'h0);
    checkOutput("post_idle_hit", 256'(lastStall), 256'(0));

    // Reset coinciding with the refill ack must leave the set invalid.
    forceLat = 100000;
    bus.cpu_req_i   = 1'b1;
    bus.cpu_write_i = 1'b0;
    bus.cpu_addr_i  = 32'h0000_0300;
    n = 0;
    while (!bus.mem_enable_o && n < 10) begin
      tick();
      n++;
    end
    checkOutput("refill_started", 256'(bus.mem_enable_o), 256'(1));
    bus.mem_ack_i  = 1'b1;
    bus.mem_data_i = {8{$urandom}};
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.mem_ack_i = 1'b0;
    bus.cpu_req_i = 1'b0;
    memBusy = 0;
    memAckReal = 0;
    forceLat = 0;
    modelReset();
    @(negedge clk);
    checkOutput("reset_abort_enable", 256'(bus.mem_enable_o), 256'(0));
    tick();
    applyStimulus(0, 32'h0000_0300, 32'h0);

    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 4) == 0) idle(int'($urandom_range(1, 3)));
      n  = int'($urandom_range(0, 3));
      t  = (n == 3) ? 23'h7ABCD : 23'(n);
      ix = 4'($urandom_range(0, 3));
      wd = 3'($urandom);
      lo = 2'($urandom);
      applyStimulus(1'($urandom_range(0, 1)), {t, ix, wd, lo}, $urandom);
    end

    idle(3);
    checkOutput("queue_drained", 256'(expQ.size()), 256'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
